mem_sram_model: RTL and testbench

//  Word-addressed, byte-strobed single-port SRAM. Sits directly downstream of axi_top's memory-side

---
 rtl/mem_sram_model.sv | 107 ++++++++++
 tb/tb_mem_sram_model.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_sram_model.sv
// Word-addressed, byte-strobed single-port SRAM with a fixed-latency, in-order response pipeline.
// Misaligned or out-of-range requests answer with err=1, rdata=0 and leave memory untouched.
module mem_sram_model #(
    parameter int MemAddrWidth = 5,
    parameter int DataWidth    = 32,
    parameter int NumWords     = 6,
    parameter int Latency      = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      mem_req_i,
    output logic                      mem_gnt_o,
    input  logic [MemAddrWidth-1:0]   mem_addr_i,
    input  logic                      mem_we_i,
    input  logic [DataWidth-1:0]      mem_wdata_i,
    input  logic [DataWidth/8-1:0]    mem_be_i,
    output logic                      mem_rvalid_o,
    output logic [DataWidth-1:0]      mem_rdata_o,
    output logic                      mem_err_o
);

    localparam int NumBytes = DataWidth / 8;
    localparam int OffBits  = $clog2(NumBytes);
    localparam int IdxWidth = (NumWords > 1) ? $clog2(NumWords) : 1;

    logic [DataWidth-1:0]    mem_q [NumWords];
    logic [MemAddrWidth-1:0] addr_word;
    logic [IdxWidth-1:0]     word_idx;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    req_err;
    logic                    accept;
    logic                    write_en;
    logic [DataWidth-1:0]    rd_word;

    logic [Latency-1:0]      pipe_valid;
    logic [Latency-1:0]      pipe_err;
    logic [DataWidth-1:0]    pipe_rdata [Latency];

    assign mem_gnt_o    = ~rst_i;
    assign accept       = mem_req_i & ~rst_i;
    assign addr_word    = mem_addr_i >> OffBits;
    assign word_idx     = addr_word[IdxWidth-1:0];
    assign out_of_range = (addr_word >= MemAddrWidth'(NumWords));

    if (OffBits > 0) begin : g_align
        assign misaligned = |mem_addr_i[OffBits-1:0];
    end else begin : g_no_align
        assign misaligned = 1'b0;
    end

    assign req_err  = misaligned | out_of_range;
    assign write_en = accept & mem_we_i & ~req_err;

    // Explicit mux keeps the read away from indices beyond NumWords.
    always_comb begin
        rd_word = '0;
        for (int w = 0; w < NumWords; w++) begin
            if (word_idx == IdxWidth'(w)) begin
                rd_word = mem_q[w];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < NumWords; w++) begin
                mem_q[w] <= '0;
            end
        end else if (write_en) begin
            for (int w = 0; w < NumWords; w++) begin
                if (word_idx == IdxWidth'(w)) begin
                    for (int b = 0; b < NumBytes; b++) begin
                        if (mem_be_i[b]) begin
                            mem_q[w][8*b +: 8] <= mem_wdata_i[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Stage 0 captures the response at the accept edge; idle cycles shift in bubbles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i < Latency; i++) begin
                pipe_rdata[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept & req_err;
            pipe_rdata[0] <= (accept && !mem_we_i && !req_err) ? rd_word : '0;
            for (int i = 1; i < Latency; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_rdata[i] <= pipe_rdata[i-1];
            end
        end
    end

    assign mem_rvalid_o = pipe_valid[Latency-1];
    assign mem_err_o    = pipe_err[Latency-1];
    assign mem_rdata_o  = pipe_rdata[Latency-1];

endmodule

// File: tb/tb_mem_sram_model.sv
// Drives identical traffic into a Latency=1 and a Latency=3 instance and checks both against
// a word-array reference with time-stamped expected responses.
module tb_mem_sram_model;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NW = 6;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          mem_req_i;
    logic [AW-1:0] mem_addr_i;
    logic          mem_we_i;
    logic [DW-1:0] mem_wdata_i;
    logic [3:0]    mem_be_i;

    logic          gnt1, rvalid1, err1;
    logic [DW-1:0] rdata1;
    logic          gnt3, rvalid3, err3;
    logic [DW-1:0] rdata3;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    logic [31:0] ref_mem [NW];
    resp_t       q1 [$];
    resp_t       q3 [$];

    always #5 clk_i = ~clk_i;

    mem_sram_model #(.MemAddrWidth(AW), .DataWidth(DW), .NumWords(NW), .Latency(1)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .mem_req_i(mem_req_i), .mem_gnt_o(gnt1),
        .mem_addr_i(mem_addr_i), .mem_we_i(mem_we_i), .mem_wdata_i(mem_wdata_i),
        .mem_be_i(mem_be_i), .mem_rvalid_o(rvalid1), .mem_rdata_o(rdata1), .mem_err_o(err1)
    );

    mem_sram_model #(.MemAddrWidth(AW), .DataWidth(DW), .NumWords(NW), .Latency(3)) u_dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .mem_req_i(mem_req_i), .mem_gnt_o(gnt3),
        .mem_addr_i(mem_addr_i), .mem_we_i(mem_we_i), .mem_wdata_i(mem_wdata_i),
        .mem_be_i(mem_be_i), .mem_rvalid_o(rvalid3), .mem_rdata_o(rdata3), .mem_err_o(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic check_resp(input string tag, input logic v, input logic e, input logic [31:0] d,
                              input logic ev, input logic ee, input logic [31:0] ed);
        chk({tag, "_rvalid"}, {31'd0, v}, {31'd0, ev});
        chk({tag, "_err"}, {31'd0, e}, {31'd0, ee});
        chk({tag, "_rdata"}, d, ed);
    endtask

    // One clock: drive inputs, check grant, update the reference at the edge, check responses.
    task automatic step(input logic rst, input logic req, input logic we, input logic [AW-1:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
        int    idx;
        logic  bad;
        resp_t r;
        rst_i       = rst;
        mem_req_i   = req;
        mem_we_i    = we;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        mem_be_i    = be;
        #1;
        chk("gnt_l1", {31'd0, gnt1}, {31'd0, ~rst});
        chk("gnt_l3", {31'd0, gnt3}, {31'd0, ~rst});
        @(posedge clk_i);
        edge_n++;
        if (rst) begin
            for (int w = 0; w < NW; w++) ref_mem[w] = 32'h0;
            q1.delete();
            q3.delete();
        end else if (req) begin
            idx = int'(addr) / 4;
            bad = (addr % 4 != 0) || (idx >= NW);
            r.err   = bad;
            r.rdata = (bad || we) ? 32'h0 : ref_mem[idx];
            r.due   = edge_n;
            q1.push_back(r);
            r.due   = edge_n + 2;
            q3.push_back(r);
            if (we && !bad) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        @(negedge clk_i);
        if (q1.size() > 0 && q1[0].due == edge_n) begin
            r = q1.pop_front();
            check_resp("l1", rvalid1, err1, rdata1, 1'b1, r.err, r.rdata);
        end else begin
            check_resp("l1", rvalid1, err1, rdata1, 1'b0, 1'b0, 32'h0);
        end
        if (q3.size() > 0 && q3[0].due == edge_n) begin
            r = q3.pop_front();
            check_resp("l3", rvalid3, err3, rdata3, 1'b1, r.err, r.rdata);
        end else begin
            check_resp("l3", rvalid3, err3, rdata3, 1'b0, 1'b0, 32'h0);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        step(1'b0, 1'b1, 1'b1, a, d, be);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, 1'b1, 1'b0, a, $urandom, 4'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 32'h0, 4'h0);
    endtask

    initial begin
        for (int w = 0; w < NW; w++) ref_mem[w] = 32'h0;
        rst_i = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0;
        mem_addr_i = '0; mem_wdata_i = '0; mem_be_i = '0;
        @(negedge clk_i);

        // Reset state, including a request held during reset that must be ignored.
        step(1'b1, 1'b0, 1'b0, '0, 32'h0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 5'h04, 32'hFFFF_FFFF, 4'hF);
        idle(4);

        // Full write then read-back; partial strobe merge.
        wr(5'h04, 32'hDEAD_BEEF, 4'hF);
        rd(5'h04);
        idle(3);
        wr(5'h04, 32'h1234_5678, 4'b0011);
        rd(5'h04);
        wr(5'h08, 32'hAAAA_AAAA, 4'h0);
        rd(5'h08);
        idle(3);

        // Back-to-back writes then back-to-back reads.
        for (int i = 0; i < NW; i++) wr(5'(4 * i), 32'h100 + 32'(i), 4'hF);
        for (int i = 0; i < NW; i++) rd(5'(4 * i));
        idle(3);

        // Error cases followed by a full sweep to confirm nothing was corrupted.
        rd(5'h02);
        rd(5'h18);
        wr(5'h1C, 32'hFFFF_FFFF, 4'hF);
        wr(5'h05, 32'hFFFF_FFFF, 4'hF);
        for (int i = 0; i < NW; i++) rd(5'(4 * i));
        idle(3);

        // Mixed read/write/read with gaps.
        rd(5'h00); wr(5'h00, 32'hCAFE_F00D, 4'hF); rd(5'h00);
        idle(1);
        rd(5'h14); idle(2); wr(5'h14, 32'h0BAD_0BAD, 4'b1100); rd(5'h14);
        idle(3);

        // Reset while Latency=3 responses are in flight.
        rd(5'h00);
        rd(5'h04);
        step(1'b1, 1'b1, 1'b0, 5'h00, 32'h0, 4'h0);
        idle(4);
        rd(5'h00);
        idle(3);

        // Randomized traffic, mostly legal addresses, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'(4 * $urandom_range(0, NW - 1));
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                 a, $urandom, 4'($urandom));
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
